// File: rtl/harmonic_phase_engine_pkg.sv
// Shared constants for the additive-oscillator harmonic phase engine:
// default widths, cutoff, FSM state codes and the LUT address slice helper.
package harmonic_phase_engine_pkg;

    localparam int DEF_PHASE_W    = 16;
    localparam int DEF_LUT_AW     = 11;
    localparam int DEF_HARM_W     = 8;
    localparam int DEF_FREQ_LIMIT = 20000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_UPDATE = 3'd2;
    localparam logic [2:0] ST_OUTPUT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The sine LUT is addressed by the top LUT_AW bits of the phase.
    function automatic int lutSliceLsb(input int phaseW, input int lutAw);
        return phaseW - lutAw;
    endfunction

endpackage

// File: rtl/harmonic_phase_engine_ram.sv
// Per-harmonic phase store: single port, synchronous write, registered read,
// contents deliberately left unreset (the first sweep after reset zeroes them).
module harmonic_phase_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_Clock,
    input  logic              i_We,
    input  logic [ADDR_W-1:0] i_Addr,
    input  logic [DATA_W-1:0] i_Wdata,
    output logic [DATA_W-1:0] o_Rdata
);

    logic [DATA_W-1:0] r_Mem [2**ADDR_W];
    logic [DATA_W-1:0] r_Rdata;

    always_ff @(posedge i_Clock) begin
        if (i_We) begin
            r_Mem[i_Addr] <= i_Wdata;
        end
        r_Rdata <= r_Mem[i_Addr];
    end

    assign o_Rdata = r_Rdata;

endmodule

// File: rtl/harmonic_phase_engine.sv
// Multi-harmonic phase accumulator: each sample tick sweeps harmonics and
// advances phase[h] by (h+1)*fundamental, presenting LUT addresses over valid/ready.
module harmonic_phase_engine
    import harmonic_phase_engine_pkg::*;
#(
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int LUT_AW     = DEF_LUT_AW,
    parameter int HARM_W     = DEF_HARM_W,
    parameter int FREQ_LIMIT = DEF_FREQ_LIMIT
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Start,
    input  logic [PHASE_W-1:0] i_Frequency,
    input  logic [HARM_W:0]   i_Num_Harmonics,
    input  logic              i_Sync,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [LUT_AW-1:0] o_Lut_Addr,
    output logic [HARM_W-1:0] o_Harmonic,
    output logic              o_Last,
    output logic              o_Busy,
    output logic              o_Sweep_Done,
    output logic              o_Freq_Too_High,
    output logic              o_Overrun
);

    localparam int INC_W   = PHASE_W + HARM_W + 1;
    localparam int NUM_W   = HARM_W + 1;
    localparam int LUT_LSB = lutSliceLsb(PHASE_W, LUT_AW);
    localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(2**HARM_W);
    localparam logic [INC_W-1:0] LIMIT   = INC_W'(FREQ_LIMIT);

    logic [2:0]         r_State;
    logic [PHASE_W-1:0] r_Freq;
    logic [INC_W-1:0]   r_Inc;
    logic [NUM_W-1:0]   r_Num;
    logic [HARM_W-1:0]  r_H;
    logic               r_SyncPending;
    logic               r_Sync;
    logic               r_Valid;
    logic [LUT_AW-1:0]  r_LutAddr;
    logic [HARM_W-1:0]  r_Harmonic;
    logic               r_Last;
    logic               r_FreqTooHigh;
    logic               r_Overrun;

    logic [NUM_W-1:0]   w_NumClamped;
    logic [PHASE_W-1:0] w_RdData;
    logic [PHASE_W-1:0] w_NewPhase;
    logic               w_OverLimit;
    logic               w_Cutoff;
    logic               w_IsLast;
    logic               w_We;

    always_comb begin
        w_NumClamped = i_Num_Harmonics;
        if (i_Num_Harmonics == '0) begin
            w_NumClamped = NUM_W'(1);
        end else if (i_Num_Harmonics > NUM_MAX) begin
            w_NumClamped = NUM_MAX;
        end
    end

    // Harmonic 0 is always produced; only higher harmonics end the sweep at the cutoff.
    assign w_OverLimit = (r_Inc > LIMIT);
    assign w_Cutoff    = w_OverLimit && (r_H != '0);
    assign w_NewPhase  = r_Sync ? '0 : (w_RdData + r_Inc[PHASE_W-1:0]);
    assign w_IsLast    = ({1'b0, r_H} == (r_Num - NUM_W'(1)));
    assign w_We        = (r_State == ST_UPDATE) && !w_Cutoff;

    harmonic_phase_ram #(
        .ADDR_W (HARM_W),
        .DATA_W (PHASE_W)
    ) u_ram (
        .i_Clock (i_Clock),
        .i_We    (w_We),
        .i_Addr  (r_H),
        .i_Wdata (w_NewPhase),
        .o_Rdata (w_RdData)
    );

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State       <= ST_IDLE;
            r_Freq        <= '0;
            r_Inc         <= '0;
            r_Num         <= '0;
            r_H           <= '0;
            r_SyncPending <= 1'b1;
            r_Sync        <= 1'b0;
            r_Valid       <= 1'b0;
            r_LutAddr     <= '0;
            r_Harmonic    <= '0;
            r_Last        <= 1'b0;
            r_FreqTooHigh <= 1'b0;
            r_Overrun     <= 1'b0;
        end else begin
            if (i_Start && (r_State != ST_IDLE)) begin
                r_Overrun <= 1'b1;
            end
            if (i_Sync) begin
                r_SyncPending <= 1'b1;
            end
            case (r_State)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_Freq        <= i_Frequency;
                        r_Inc         <= INC_W'(i_Frequency);
                        r_Num         <= w_NumClamped;
                        r_H           <= '0;
                        // A sync sampled together with the start applies to this sweep.
                        r_Sync        <= r_SyncPending | i_Sync;
                        r_SyncPending <= 1'b0;
                        r_FreqTooHigh <= 1'b0;
                        r_State       <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_State <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (w_OverLimit) begin
                        r_FreqTooHigh <= 1'b1;
                    end
                    if (w_Cutoff) begin
                        r_State <= ST_DONE;
                    end else begin
                        r_LutAddr  <= w_NewPhase[LUT_LSB +: LUT_AW];
                        r_Harmonic <= r_H;
                        r_Last     <= w_IsLast;
                        r_Valid    <= 1'b1;
                        r_State    <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (i_Ready) begin
                        r_Valid <= 1'b0;
                        if (r_Last) begin
                            r_State <= ST_DONE;
                        end else begin
                            r_H     <= r_H + HARM_W'(1);
                            r_Inc   <= r_Inc + INC_W'(r_Freq);
                            r_State <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_State <= ST_IDLE;
                end
                default: begin
                    r_State <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Valid         = r_Valid;
    assign o_Lut_Addr      = r_LutAddr;
    assign o_Harmonic      = r_Harmonic;
    assign o_Last          = r_Last;
    assign o_Busy          = (r_State != ST_IDLE);
    assign o_Sweep_Done    = (r_State == ST_DONE);
    assign o_Freq_Too_High = r_FreqTooHigh;
    assign o_Overrun       = r_Overrun;

endmodule

// File: tb/tb_harmonic_phase_engine.sv
// Directed bench for harmonic_phase_engine: a table of whole sweeps with
// hand-computed LUT addresses, then hand-written stall, overrun and reset sequences.
module tb_harmonic_phase_engine;

    logic        clock = 1'b0;
    logic        resetN;
    logic        iStart;
    logic [15:0] iFrequency;
    logic [8:0]  iNumHarmonics;
    logic        iSync;
    logic        oValid;
    logic        iReady;
    logic [10:0] oLutAddr;
    logic [7:0]  oHarmonic;
    logic        oLast;
    logic        oBusy;
    logic        oSweepDone;
    logic        oFreqTooHigh;
    logic        oOverrun;

    int testCount = 0;
    int failCount = 0;

    int capAddr [256];
    int capHarm [256];
    int capLast [256];
    int capCount;
    int doneCount;
    int tooHighAtEnd;
    bit finished;

    typedef struct packed {
        int                freq;
        int                num;
        bit                syncStart;
        int                syncMid;
        int                expCount;
        int                expLastIdx;
        bit                expTooHigh;
        logic [7:0][10:0]  expAddr;
    } vec_t;

    vec_t vecs [11];

    always #5 clock = ~clock;

    harmonic_phase_engine dut (
        .i_Clock         (clock),
        .i_Reset_n       (resetN),
        .i_Start         (iStart),
        .i_Frequency     (iFrequency),
        .i_Num_Harmonics (iNumHarmonics),
        .i_Sync          (iSync),
        .o_Valid         (oValid),
        .i_Ready         (iReady),
        .o_Lut_Addr      (oLutAddr),
        .o_Harmonic      (oHarmonic),
        .o_Last          (oLast),
        .o_Busy          (oBusy),
        .o_Sweep_Done    (oSweepDone),
        .o_Freq_Too_High (oFreqTooHigh),
        .o_Overrun       (oOverrun)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setVec(input int idx, input int freq, input int num, input bit syncStart,
                          input int syncMid, input int cnt, input int lastIdx, input bit tooHigh,
                          input int a0, input int a1, input int a2, input int a3,
                          input int a4, input int a5, input int a6, input int a7);
        vecs[idx].freq       = freq;
        vecs[idx].num        = num;
        vecs[idx].syncStart  = syncStart;
        vecs[idx].syncMid    = syncMid;
        vecs[idx].expCount   = cnt;
        vecs[idx].expLastIdx = lastIdx;
        vecs[idx].expTooHigh = tooHigh;
        vecs[idx].expAddr[0] = 11'(a0);
        vecs[idx].expAddr[1] = 11'(a1);
        vecs[idx].expAddr[2] = 11'(a2);
        vecs[idx].expAddr[3] = 11'(a3);
        vecs[idx].expAddr[4] = 11'(a4);
        vecs[idx].expAddr[5] = 11'(a5);
        vecs[idx].expAddr[6] = 11'(a6);
        vecs[idx].expAddr[7] = 11'(a7);
    endtask

    // Pulse i_Start for one edge; returns at the falling edge after that edge.
    task automatic applyStimulus(input int freq, input int num, input bit syncStart);
        @(negedge clock);
        iFrequency    = freq[15:0];
        iNumHarmonics = num[8:0];
        iStart        = 1'b1;
        iSync         = syncStart;
        @(negedge clock);
        iStart = 1'b0;
        iSync  = 1'b0;
    endtask

    task automatic runSweep(input int syncMid, input int startMid);
        capCount  = 0;
        doneCount = 0;
        finished  = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(negedge clock);
            if (oValid && iReady) begin
                if (capCount < 256) begin
                    capAddr[capCount] = int'(oLutAddr);
                    capHarm[capCount] = int'(oHarmonic);
                    capLast[capCount] = int'(oLast);
                end
                capCount++;
            end
            if (oSweepDone) doneCount++;
            iSync  = (k == syncMid);
            iStart = (k == startMid);
            if (doneCount > 0 && !oBusy) finished = 1'b1;
        end
        iSync        = 1'b0;
        iStart       = 1'b0;
        tooHighAtEnd = int'(oFreqTooHigh);
        checkOutput("sweep_finished", int'(finished), 1);
    endtask

    task automatic checkAddrs(input string tag, input int cnt, input int a0, input int a1,
                              input int a2, input int a3);
        int exp [4];
        exp[0] = a0; exp[1] = a1; exp[2] = a2; exp[3] = a3;
        checkOutput({tag, "_count"}, capCount, cnt);
        for (int i = 0; i < cnt && i < capCount; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), capAddr[i], exp[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), capLast[i], int'(i == cnt - 1));
        end
    endtask

    initial begin
        int lat;
        int holdAddr;
        resetN        = 1'b0;
        iStart        = 1'b0;
        iSync         = 1'b0;
        iReady        = 1'b1;
        iFrequency    = '0;
        iNumHarmonics = '0;

        //      idx freq   num  syS  syM cnt last th  addresses
        setVec(0,  1000,  4,   0,  -1, 4,   3,   0,  0,    0,   0,   0,   0, 0, 0, 0);
        setVec(1,  1000,  4,   0,   5, 4,   3,   0,  31,   62,  93,  125, 0, 0, 0, 0);
        setVec(2,  1000,  4,   0,  -1, 4,   3,   0,  0,    0,   0,   0,   0, 0, 0, 0);
        setVec(3,  1000,  4,   0,  -1, 4,   3,   0,  31,   62,  93,  125, 0, 0, 0, 0);
        setVec(4,  6000,  8,   0,  -1, 3,  -1,   1,  218,  437, 656, 0,   0, 0, 0, 0);
        setVec(5,  1000,  4,   0,  -1, 4,   3,   0,  250,  500, 750, 250, 0, 0, 0, 0);
        setVec(6,  1000,  0,   0,  -1, 1,   0,   0,  281,  0,   0,   0,   0, 0, 0, 0);
        setVec(7,  40000, 1,   1,  -1, 1,   0,   1,  0,    0,   0,   0,   0, 0, 0, 0);
        setVec(8,  40000, 1,   0,  -1, 1,   0,   1,  1250, 0,   0,   0,   0, 0, 0, 0);
        setVec(9,  40000, 1,   0,  -1, 1,   0,   1,  452,  0,   0,   0,   0, 0, 0, 0);
        setVec(10, 0,     300, 1,  -1, 256, 255, 0,  0,    0,   0,   0,   0, 0, 0, 0);

        repeat (2) @(negedge clock);
        checkOutput("reset_outputs",
                    int'({oValid, oLutAddr, oHarmonic, oLast, oBusy, oSweepDone, oFreqTooHigh, oOverrun}), 0);
        resetN = 1'b1;

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].freq, vecs[v].num, vecs[v].syncStart);
            runSweep(vecs[v].syncMid, -1);
            checkOutput($sformatf("v%0d_count", v), capCount, vecs[v].expCount);
            checkOutput($sformatf("v%0d_done", v), doneCount, 1);
            checkOutput($sformatf("v%0d_toohigh", v), tooHighAtEnd, int'(vecs[v].expTooHigh));
            for (int i = 0; i < capCount && i < 256; i++) begin
                if (i < 8)
                    checkOutput($sformatf("v%0d_addr%0d", v, i), capAddr[i], int'(vecs[v].expAddr[i]));
                checkOutput($sformatf("v%0d_harm%0d", v, i), capHarm[i], i);
                checkOutput($sformatf("v%0d_last%0d", v, i), capLast[i], int'(i == vecs[v].expLastIdx));
            end
        end
        checkOutput("overrun_clear", int'(oOverrun), 0);

        // Start while busy is ignored but flagged; all phases are 0 here.
        applyStimulus(1000, 4, 1'b0);
        runSweep(-1, 4);
        checkAddrs("ovr", 4, 31, 62, 93, 125);
        checkOutput("ovr_done", doneCount, 1);
        checkOutput("ovr_flag", int'(oOverrun), 1);
        repeat (3) @(negedge clock);
        checkOutput("ovr_no_restart", int'(oBusy), 0);
        applyStimulus(1000, 2, 1'b0);
        runSweep(-1, -1);
        checkAddrs("ovr2", 2, 62, 125, 0, 0);
        checkOutput("ovr_sticky", int'(oOverrun), 1);

        // Backpressure on h0: outputs frozen, then 3-cycle latency after acceptance.
        iReady = 1'b0;
        applyStimulus(1000, 2, 1'b0);
        lat = 1;
        while (!oValid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("start_latency", lat, 3);
        holdAddr = int'(oLutAddr);
        checkOutput("stall_addr0", holdAddr, 93);
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            checkOutput($sformatf("stall_valid%0d", s), int'(oValid), 1);
            checkOutput($sformatf("stall_addr%0d", s), int'(oLutAddr), 93);
            checkOutput($sformatf("stall_harm%0d", s), int'(oHarmonic), 0);
        end
        iReady = 1'b1;
        @(negedge clock);
        lat = 1;
        while (!oValid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("accept_latency", lat, 3);
        checkOutput("stall_h1_addr", int'(oLutAddr), 187);
        checkOutput("stall_h1_harm", int'(oHarmonic), 1);
        checkOutput("stall_h1_last", int'(oLast), 1);
        runSweep(-1, -1);

        // Asynchronous reset in the middle of an output phase.
        iReady = 1'b0;
        applyStimulus(1000, 2, 1'b0);
        lat = 1;
        while (!oValid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("pre_reset_valid", int'(oValid), 1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("reset_valid_drop", int'(oValid), 0);
        checkOutput("reset_overrun", int'(oOverrun), 0);
        checkOutput("reset_busy", int'(oBusy), 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        iReady = 1'b1;
        applyStimulus(1000, 2, 1'b0);
        runSweep(-1, -1);
        checkAddrs("post_rst", 2, 0, 0, 0, 0);
        applyStimulus(1000, 2, 1'b0);
        runSweep(-1, -1);
        checkAddrs("post_rst2", 2, 31, 62, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
